seg7_scan_decoder: RTL and testbench

//  Receive-side counterpart of the hex-to-seven-segment path.
//  - Monitors a time-multiplexed 7-segment display bus: active-low segments plus active-low digit enables.
//  - Qualifies each pattern for stability, then decodes it back to a hex nibble.
//  - Assembles one full N_DIGITS-digit word and presents it on a valid/ready interface.
//  - Used for display loop-back checking and for scraping external display drivers.

---
 rtl/seg7_scan_decoder.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//   Watches a time-multiplexed seven-segment display bus, waits for each digit
//   pattern to settle, decodes it back to a hex nibble and assembles a full
//   N_DIGITS-digit word. Each word is offered on a valid/ready interface.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous active-high reset
//   i_seg[6:0]    segments, active-low, {g,f,e,d,c,b,a}
//   i_an[N-1:0]   digit enables, active-low, bit k selects digit k
//   o_data        decoded word, digit k at [4k+3:4k]
//   o_valid       o_data / o_err valid
//   i_ready       consumer accepts the word when o_valid && i_ready
//   o_err         published word held at least one unrecognised pattern
//   o_digit_mask  digits captured so far in the staging frame
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_seg,
  input  logic [N_DIGITS-1:0]   i_an,
  output logic [4*N_DIGITS-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_err,
  output logic [N_DIGITS-1:0]   o_digit_mask
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  // The capture fires on the comparison that moves the counter into CNT_MAX.
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h18:   res = 5'h09;
      7'h08:   res = 5'h0A;
      7'h03:   res = 5'h0B;
      7'h46:   res = 5'h0C;
      7'h21:   res = 5'h0D;
      7'h06:   res = 5'h0E;
      7'h0E:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  logic [6:0]            r_seg_p0;
  logic [N_DIGITS-1:0]   r_an_p0;
  logic [6:0]            r_seg_p1;
  logic [N_DIGITS-1:0]   r_an_p1;
  logic [CNT_W-1:0]      r_cnt;
  logic [4*N_DIGITS-1:0] r_stage;
  logic [N_DIGITS-1:0]   r_err_stage;
  logic [N_DIGITS-1:0]   r_mask;
  logic [4*N_DIGITS-1:0] r_data;
  logic                  r_valid;
  logic                  r_err;
  state_t                r_state;

  logic                  w_same;
  logic                  w_capture;
  logic [4:0]            w_dec;
  logic [N_DIGITS-1:0]   w_cap_sel;
  logic [N_DIGITS-1:0]   w_mask_nxt;
  logic [N_DIGITS-1:0]   w_err_nxt;
  logic                  w_publish;
  logic                  w_ack;
  state_t                w_state_nxt;

  // Stage p0/p1: current sample and previous sample of the display bus
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg_p0 <= 7'h7F;
      r_an_p0  <= '1;
      r_seg_p1 <= 7'h7F;
      r_an_p1  <= '1;
    end else begin
      r_seg_p0 <= i_seg;
      r_an_p0  <= i_an;
      r_seg_p1 <= r_seg_p0;
      r_an_p1  <= r_an_p0;
    end
  end

  assign w_same    = (r_seg_p0 == r_seg_p1) && (r_an_p0 == r_an_p1);
  // Blank or multi-digit enables keep the counter running but never capture.
  assign w_capture = w_same && (r_cnt == CNT_ARM) && $onehot(~r_an_p0);
  assign w_dec     = decode_seg(r_seg_p0);
  assign w_cap_sel = w_capture ? ~r_an_p0 : '0;

  // A publish clears the frame first so a same-edge capture lands in the new frame.
  assign w_mask_nxt = (w_publish ? '0 : r_mask) | w_cap_sel;
  assign w_err_nxt  = ((w_publish ? '0 : r_err_stage) & ~w_cap_sel) |
                      (w_dec[4] ? w_cap_sel : '0);

  // Stage p2: stability counter and staging frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_mask      <= '0;
      r_err_stage <= '0;
      r_stage     <= '0;
    end else begin
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
      r_mask      <= w_mask_nxt;
      r_err_stage <= w_err_nxt;
      for (int k = 0; k < N_DIGITS; k++) begin
        if (w_cap_sel[k])
          r_stage[4*k +: 4] <= w_dec[3:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (&r_mask) begin
          w_publish   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (r_valid && i_ready) begin
          w_ack       = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Stage p3: published word, frozen while waiting for the consumer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= COLLECT;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_publish) begin
        r_data  <= r_stage;
        r_err   <= |r_err_stage;
        r_valid <= 1'b1;
      end else if (w_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_err        = r_err;
  assign o_digit_mask = r_mask;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//   Directed bench for seg7_scan_decoder (N_DIGITS=4, STABLE_CYCLES=4).
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        err;
  logic [3:0]  mask;

  int n_tests;
  int n_fail;

  seg7_scan_decoder #(
    .N_DIGITS      (4),
    .STABLE_CYCLES (4)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_seg        (seg),
    .i_an         (an),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_err        (err),
    .o_digit_mask (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    step(n);
  endtask

  task automatic handshake();
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    ready   = 1'b0;
    an      = 4'hF;
    seg     = 7'h7F;
    step(3);
    check("rst_data", data, 16'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mask", mask, 4'h0);
    rst = 1'b0;

    // Frame F5A1
    drive(4'b1110, 7'h79, 10);
    check("t1_mask0", mask, 4'b0001);
    drive(4'b1101, 7'h08, 10);
    drive(4'b1011, 7'h12, 10);
    check("t1_mask012", mask, 4'b0111);
    drive(4'b0111, 7'h0E, 10);
    check("t1_valid", valid, 1'b1);
    check("t1_data", data, 16'hF5A1);
    check("t1_err", err, 1'b0);
    check("t1_mask_cleared", mask, 4'h0);

    // Frame 1234 staged while the consumer stalls
    drive(4'b1110, 7'h19, 10);
    drive(4'b1101, 7'h30, 10);
    drive(4'b1011, 7'h24, 10);
    drive(4'b0111, 7'h79, 10);
    check("t4_hold_valid", valid, 1'b1);
    check("t4_hold_data", data, 16'hF5A1);
    check("t4_mask_full", mask, 4'hF);
    handshake();
    check("t4_valid_drop", valid, 1'b0);
    step(1);
    check("t4_valid2", valid, 1'b1);
    check("t4_data2", data, 16'h1234);
    check("t4_err2", err, 1'b0);
    check("t4_mask2", mask, 4'h0);
    handshake();
    check("t4_ack2", valid, 1'b0);

    // Short hold never captures
    drive(4'b1110, 7'h40, 3);
    drive(4'b1111, 7'h7F, 10);
    check("t2_no_capture", mask, 4'h0);

    // Unrecognised pattern on digit 2
    drive(4'b1110, 7'h79, 10);
    drive(4'b1101, 7'h08, 10);
    drive(4'b1011, 7'h7F, 10);
    drive(4'b0111, 7'h0E, 10);
    check("t3_valid", valid, 1'b1);
    check("t3_data", data, 16'hF0A1);
    check("t3_err", err, 1'b1);
    handshake();
    check("t3_ack", valid, 1'b0);

    // Blank and multi-low enables
    drive(4'b1111, 7'h00, 20);
    check("t5_blank_mask", mask, 4'h0);
    check("t5_blank_valid", valid, 1'b0);
    drive(4'b1100, 7'h00, 20);
    check("t5_multi_mask", mask, 4'h0);
    check("t5_multi_valid", valid, 1'b0);

    // Reset mid-frame discards captured digits
    drive(4'b1110, 7'h79, 10);
    drive(4'b1101, 7'h08, 10);
    check("t6_mask_pre", mask, 4'b0011);
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    step(1);
    rst = 1'b0;
    check("t6_mask_rst", mask, 4'h0);
    check("t6_valid_rst", valid, 1'b0);
    check("t6_data_rst", data, 16'h0);
    drive(4'b1011, 7'h12, 10);
    drive(4'b0111, 7'h0E, 10);
    check("t6_mask_half", mask, 4'b1100);
    check("t6_no_valid", valid, 1'b0);
    drive(4'b1110, 7'h79, 10);
    drive(4'b1101, 7'h08, 10);
    check("t6_valid", valid, 1'b1);
    check("t6_data", data, 16'hF5A1);
    check("t6_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
